// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with manual select and auto-scan mode
module mux_scan_n #(
    parameter  int BITS        = 4,
    parameter  int CHANNELS    = 8,
    parameter  int SCAN_PERIOD = 4,
    localparam int SELW        = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS*BITS-1:0] D,
    input  logic [SELW-1:0]          SEL,
    input  logic                     mode,
    input  logic                     hold,
    output logic [BITS-1:0]          MUX_OUT,
    output logic [SELW-1:0]          CH_OUT,
    output logic                     valid,
    output logic                     new_ch
);

    localparam int PW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;

    typedef enum logic {ST_MANUAL, ST_SCAN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SELW-1:0] ch_next;
    logic [SELW-1:0] ch_wrap;
    logic [BITS-1:0] data_next;
    logic            in_range;
    logic            terminal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = mode ? ST_SCAN : ST_MANUAL;
    end

    // Explicit compare keeps the wrap correct for non power-of-2 channel counts
    assign ch_wrap  = (CH_OUT == SELW'(CHANNELS - 1)) ? '0 : CH_OUT + SELW'(1);
    assign terminal = (presc_q == PW'(SCAN_PERIOD - 1));

    // Precedence: mode entry/exit, then hold, then terminal count
    always_comb begin
        ch_next = CH_OUT;
        presc_d = presc_q;
        if (!mode) begin
            ch_next = SEL;
            presc_d = '0;
        end else if (state_q == ST_MANUAL) begin
            ch_next = '0;
            presc_d = '0;
        end else if (hold) begin
            ch_next = CH_OUT;
            presc_d = presc_q;
        end else if (terminal) begin
            ch_next = ch_wrap;
            presc_d = '0;
        end else begin
            ch_next = CH_OUT;
            presc_d = presc_q + PW'(1);
        end
    end

    // Out-of-range manual selects yield all ones and drop valid
    always_comb begin
        data_next = {BITS{1'b1}};
        in_range  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_next == SELW'(k)) begin
                data_next = D[k*BITS +: BITS];
                in_range  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            MUX_OUT <= '0;
            CH_OUT  <= '0;
            valid   <= 1'b0;
            new_ch  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            MUX_OUT <= data_next;
            CH_OUT  <= ch_next;
            valid   <= in_range;
            new_ch  <= (ch_next != CH_OUT);
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed bench for mux_scan_n (6-channel/period-4 and 8-channel/period-1)
module tb_mux_scan_n;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [23:0] d6;
    logic [2:0]  sel6;
    logic        mode6, hold6;
    logic [3:0]  mux6;
    logic [2:0]  ch6;
    logic        valid6, new6;

    logic [31:0] d8;
    logic [2:0]  sel8;
    logic        mode8, hold8;
    logic [3:0]  mux8;
    logic [2:0]  ch8;
    logic        valid8, new8;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mux_scan_n #(.BITS(4), .CHANNELS(6), .SCAN_PERIOD(4)) dut (
        .clock(clock), .reset(reset), .D(d6), .SEL(sel6), .mode(mode6), .hold(hold6),
        .MUX_OUT(mux6), .CH_OUT(ch6), .valid(valid6), .new_ch(new6)
    );

    mux_scan_n #(.BITS(4), .CHANNELS(8), .SCAN_PERIOD(1)) dut8 (
        .clock(clock), .reset(reset), .D(d8), .SEL(sel8), .mode(mode8), .hold(hold8),
        .MUX_OUT(mux8), .CH_OUT(ch8), .valid(valid8), .new_ch(new8)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        sel6 = 3'd5; mode6 = 1'b0; hold6 = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        checks++;
        if (ch6 !== 3'd5) begin errors++; $display("FAIL reset_pre ch: got %0d expected 5", ch6); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mux6, ch6, valid6, new6} !== 9'd0) begin
            errors++; $display("FAIL reset_async6: got mux=%0h ch=%0d v=%0b n=%0b expected all 0", mux6, ch6, valid6, new6);
        end
        checks++;
        if ({mux8, ch8, valid8, new8} !== 9'd0) begin
            errors++; $display("FAIL reset_async8: got mux=%0h ch=%0d v=%0b n=%0b expected all 0", mux8, ch8, valid8, new8);
        end
        #2 reset = 1'b0;
    endtask

    task automatic test_manual;
        sel6 = 3'd5; sel8 = 3'd5;
        tick(1);
        checks++;
        if ({mux6, ch6, valid6, new6} !== {4'd6, 3'd5, 1'b1, 1'b1}) begin
            errors++; $display("FAIL manual6_sel5: got mux=%0h ch=%0d v=%0b n=%0b expected 6 5 1 1", mux6, ch6, valid6, new6);
        end
        checks++;
        if ({mux8, ch8, valid8, new8} !== {4'd6, 3'd5, 1'b1, 1'b1}) begin
            errors++; $display("FAIL manual8_sel5: got mux=%0h ch=%0d v=%0b n=%0b expected 6 5 1 1", mux8, ch8, valid8, new8);
        end
        tick(1);
        checks++;
        if ({mux6, new6} !== {4'd6, 1'b0}) begin
            errors++; $display("FAIL manual6_steady: got mux=%0h n=%0b expected 6 0", mux6, new6);
        end
        sel8 = 3'd7;
        tick(1);
        checks++;
        if ({mux8, ch8, valid8, new8} !== {4'd8, 3'd7, 1'b1, 1'b1}) begin
            errors++; $display("FAIL manual8_last: got mux=%0h ch=%0d v=%0b n=%0b expected 8 7 1 1", mux8, ch8, valid8, new8);
        end
    endtask

    task automatic test_out_of_range;
        sel6 = 3'd7;
        tick(1);
        checks++;
        if ({mux6, ch6, valid6, new6} !== {4'hF, 3'd7, 1'b0, 1'b1}) begin
            errors++; $display("FAIL oor_sel7: got mux=%0h ch=%0d v=%0b n=%0b expected f 7 0 1", mux6, ch6, valid6, new6);
        end
        sel6 = 3'd6;
        tick(1);
        checks++;
        if ({mux6, ch6, valid6} !== {4'hF, 3'd6, 1'b0}) begin
            errors++; $display("FAIL oor_sel6: got mux=%0h ch=%0d v=%0b expected f 6 0", mux6, ch6, valid6);
        end
    endtask

    task automatic test_scan_wrap;
        logic [2:0] exp_ch;
        mode6 = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            tick(1);
            exp_ch = 3'((i / 4) % 6);
            checks++;
            if ({ch6, mux6, valid6, new6} !== {exp_ch, 4'(exp_ch + 3'd1), 1'b1, (i % 4) == 0}) begin
                errors++;
                $display("FAIL scan_step%0d: got ch=%0d mux=%0h v=%0b n=%0b expected ch=%0d mux=%0h v=1 n=%0b",
                         i, ch6, mux6, valid6, new6, exp_ch, exp_ch + 3'd1, (i % 4) == 0);
            end
        end
    endtask

    task automatic test_hold;
        tick(9);
        checks++;
        if (ch6 !== 3'd2) begin errors++; $display("FAIL hold_setup: got ch=%0d expected 2", ch6); end
        hold6 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checks++;
            if ({ch6, new6, mux6} !== {3'd2, 1'b0, 4'd3}) begin
                errors++; $display("FAIL hold_freeze%0d: got ch=%0d n=%0b mux=%0h expected 2 0 3", i, ch6, new6, mux6);
            end
        end
        d6[8 +: 4] = 4'hA;
        tick(1);
        checks++;
        if ({ch6, mux6} !== {3'd2, 4'hA}) begin
            errors++; $display("FAIL hold_track: got ch=%0d mux=%0h expected 2 a", ch6, mux6);
        end
        d6[8 +: 4] = 4'd3;
        hold6 = 1'b0;
        tick(2);
        checks++;
        if (ch6 !== 3'd2) begin errors++; $display("FAIL hold_resume_wait: got ch=%0d expected 2", ch6); end
        tick(1);
        checks++;
        if ({ch6, new6, mux6} !== {3'd3, 1'b1, 4'd4}) begin
            errors++; $display("FAIL hold_resume_step: got ch=%0d n=%0b mux=%0h expected 3 1 4", ch6, new6, mux6);
        end
    endtask

    task automatic test_mode_switch;
        tick(3);
        sel6 = 3'd1; mode6 = 1'b0;
        tick(1);
        checks++;
        if ({ch6, mux6, new6} !== {3'd1, 4'd2, 1'b1}) begin
            errors++; $display("FAIL exit_at_tc: got ch=%0d mux=%0h n=%0b expected 1 2 1", ch6, mux6, new6);
        end
        mode6 = 1'b1;
        tick(1);
        checks++;
        if ({ch6, mux6, new6} !== {3'd0, 4'd1, 1'b1}) begin
            errors++; $display("FAIL entry: got ch=%0d mux=%0h n=%0b expected 0 1 1", ch6, mux6, new6);
        end
        tick(3);
        checks++;
        if ({ch6, new6} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL entry_dwell: got ch=%0d n=%0b expected 0 0", ch6, new6);
        end
        tick(1);
        checks++;
        if (ch6 !== 3'd1) begin errors++; $display("FAIL entry_advance: got ch=%0d expected 1", ch6); end
    endtask

    task automatic test_reset_mid_scan;
        tick(2);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ch6, valid6} !== 4'd0) begin
            errors++; $display("FAIL midscan_reset: got ch=%0d v=%0b expected 0 0", ch6, valid6);
        end
        #2 reset = 1'b0;
        tick(1);
        checks++;
        if ({ch6, valid6, new6} !== {3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL midscan_restart: got ch=%0d v=%0b n=%0b expected 0 1 0", ch6, valid6, new6);
        end
        tick(3);
        checks++;
        if (ch6 !== 3'd0) begin errors++; $display("FAIL midscan_dwell: got ch=%0d expected 0", ch6); end
        tick(1);
        checks++;
        if (ch6 !== 3'd1) begin errors++; $display("FAIL midscan_advance: got ch=%0d expected 1", ch6); end
    endtask

    task automatic test_scan_period1;
        mode8 = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick(1);
            checks++;
            if ({ch8, mux8, new8} !== {3'(i % 8), 4'((i % 8) + 1), 1'b1}) begin
                errors++; $display("FAIL p1_step%0d: got ch=%0d mux=%0h n=%0b expected ch=%0d n=1", i, ch8, mux8, new8, i % 8);
            end
        end
        hold8 = 1'b1;
        tick(1);
        checks++;
        if ({ch8, new8} !== {3'd0, 1'b0}) begin
            errors++; $display("FAIL p1_hold: got ch=%0d n=%0b expected 0 0", ch8, new8);
        end
        hold8 = 1'b0;
        tick(1);
        checks++;
        if (ch8 !== 3'd1) begin errors++; $display("FAIL p1_release: got ch=%0d expected 1", ch8); end
    endtask

    initial begin
        for (int k = 0; k < 6; k++) d6[k*4 +: 4] = 4'(k + 1);
        for (int k = 0; k < 8; k++) d8[k*4 +: 4] = 4'(k + 1);
        sel6 = '0; mode6 = 1'b0; hold6 = 1'b0;
        sel8 = '0; mode8 = 1'b0; hold8 = 1'b0;
        test_reset;
        test_manual;
        test_out_of_range;
        test_scan_wrap;
        test_hold;
        test_mode_switch;
        test_reset_mid_scan;
        test_scan_period1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
